// File: rtl/tmds_encoder_pipe_if.sv
// Pixel-side bundle for the TMDS encoder: mode/payload in,
// encoded symbols and running disparity out.
interface tmds_encoder_pipe_if #(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 6
);
  logic                     in_ce;
  logic [1:0]               in_mode;
  logic [NUM_CH*8-1:0]      in_data;
  logic [NUM_CH*2-1:0]      in_ctrl;
  logic [NUM_CH*4-1:0]      in_terc;
  logic [NUM_CH*10-1:0]     out_tmds;
  logic [NUM_CH*DISP_W-1:0] out_disp;

  modport master (
    output in_ce, in_mode, in_data,
    output in_ctrl, in_terc,
    input  out_tmds, out_disp
  );

  modport slave (
    input  in_ce, in_mode, in_data,
    input  in_ctrl, in_terc,
    output out_tmds, out_disp
  );
endinterface

// File: rtl/tmds_encoder_pipe.sv
// Two-stage TMDS/HDMI encoder: S1 builds q_m per lane,
// S2 applies running-disparity balancing or fixed codes.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 6
) (
  input logic            pix_clk,
  input logic            rst_n,
  tmds_encoder_pipe_if.slave bus
);

  localparam logic [9:0] CTRL0 = 10'b1101010100;

  typedef logic signed [DISP_W-1:0] disp_t;

  localparam disp_t ZERO  = disp_t'(0);
  localparam disp_t TWO   = disp_t'(2);
  localparam disp_t EIGHT = disp_t'(8);

  typedef struct packed {
    logic [8:0] qm;
    logic [3:0] n1;
    logic [1:0] ctrl;
    logic [3:0] terc;
  } s1_t;

  function automatic logic [3:0] ones8(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++)
      n = n + {3'b000, v[k]};
    return n;
  endfunction

  function automatic logic [8:0] qm_of(
    input logic [7:0] d
  );
    logic [3:0] n;
    logic       xn;
    logic [8:0] q;
    n = ones8(d);
    xn = (n > 4'd4) ||
         (n == 4'd4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int k = 1; k < 8; k++)
      q[k] = xn ? ~(q[k-1] ^ d[k])
                :  (q[k-1] ^ d[k]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_of(
    input logic [1:0] c
  );
    logic [9:0] s;
    unique case (c)
      2'd0: s = 10'b1101010100;
      2'd1: s = 10'b0010101011;
      2'd2: s = 10'b0101010100;
      2'd3: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc_of(
    input logic [3:0] t
  );
    logic [9:0] s;
    unique case (t)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      4'hF: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [1:0] mode_q;

  always_ff @(posedge pix_clk) begin
    if (!rst_n)
      mode_q <= 2'd0;
    else if (bus.in_ce)
      mode_q <= bus.in_mode;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam logic [9:0] GUARD =
      (i % 3 == 1) ? 10'b0100110011
                   : 10'b1011001100;

    logic [8:0] qm;
    s1_t        s1_d;
    s1_t        s1_q;
    logic [9:0] sym_d;
    logic [9:0] sym_q;
    disp_t      cnt_d;
    disp_t      cnt_q;
    disp_t      n1s;
    disp_t      diff;
    logic       q8;
    logic [7:0] q;

    assign qm = qm_of(bus.in_data[8*i +: 8]);

    assign s1_d = '{
      qm:   qm,
      n1:   ones8(qm[7:0]),
      ctrl: bus.in_ctrl[2*i +: 2],
      terc: bus.in_terc[4*i +: 4]
    };

    always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
        s1_q  <= '0;
        sym_q <= CTRL0;
        cnt_q <= ZERO;
      end else if (bus.in_ce) begin
        s1_q  <= s1_d;
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end

    assign q8 = s1_q.qm[8];
    assign q  = s1_q.qm[7:0];

    // diff = N1 - N0 of q_m[7:0]
    assign n1s  = disp_t'({1'b0, s1_q.n1});
    assign diff = n1s + n1s - EIGHT;

    always_comb begin
      sym_d = CTRL0;
      cnt_d = ZERO;
      unique case (mode_q)
        2'd0: sym_d = ctrl_of(s1_q.ctrl);
        2'd2: sym_d = terc_of(s1_q.terc);
        2'd3: sym_d = GUARD;
        2'd1: begin
          unique case (1'b1)
            (cnt_q == ZERO ||
             s1_q.n1 == 4'd4): begin
              sym_d = {~q8, q8,
                       q8 ? q : ~q};
              cnt_d = q8 ? cnt_q + diff
                         : cnt_q - diff;
            end
            ((cnt_q > ZERO &&
              s1_q.n1 > 4'd4) ||
             (cnt_q < ZERO &&
              s1_q.n1 < 4'd4)): begin
              sym_d = {1'b1, q8, ~q};
              cnt_d = cnt_q - diff +
                      (q8 ? TWO : ZERO);
            end
            default: begin
              sym_d = {1'b0, q8, q};
              cnt_d = cnt_q + diff -
                      (q8 ? ZERO : TWO);
            end
          endcase
        end
      endcase
    end

    assign bus.out_tmds[10*i +: 10] = sym_q;
    assign bus.out_disp[DISP_W*i +: DISP_W] =
      cnt_q;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Scoreboard bench for tmds_encoder_pipe: behavioural model
// feeds a queue, an edge monitor pops and compares.
module tb_tmds_encoder_pipe;

  localparam int NCH = 4;
  localparam int DW  = 6;
  localparam logic [9:0] CTRL0 = 10'b1101010100;

  localparam logic [9:0] CTL [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011
  };

  typedef struct {
    logic [NCH*10-1:0] tmds;
    logic [NCH*DW-1:0] disp;
    bit                video;
    logic [NCH*8-1:0]  data;
  } exp_t;

  logic pix_clk = 1'b0;
  logic rst_n;

  tmds_encoder_pipe_if #(
    .NUM_CH(NCH), .DISP_W(DW)
  ) bus ();

  tmds_encoder_pipe #(
    .NUM_CH(NCH), .DISP_W(DW)
  ) dut (
    .pix_clk(pix_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 pix_clk = ~pix_clk;

  exp_t sb[$];
  exp_t last;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cnt[NCH];

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference video encoding in plain integer terms
  function automatic logic [9:0] enc_video(
    input int         ln,
    input logic [7:0] d
  );
    int         n1d, n1, n0;
    bit         xn;
    logic [8:0] qm;
    logic [9:0] s;
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int k = 1; k < 8; k++)
      qm[k] = xn ? !(qm[k-1] ^ d[k])
                 :  (qm[k-1] ^ d[k]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt[ln] == 0 || n1 == 4) begin
      s = {!qm[8], qm[8],
           qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt[ln] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt[ln] > 0 && n1 > 4) ||
                 (cnt[ln] < 0 && n1 < 4)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt[ln] += (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt[ln] += (qm[8] ? 0 : -2) + (n1 - n0);
    end
    return s;
  endfunction

  function automatic exp_t model(
    input logic [1:0]       mode,
    input logic [NCH*8-1:0] data,
    input logic [NCH*2-1:0] ctrl,
    input logic [NCH*4-1:0] terc
  );
    exp_t       e;
    logic [9:0] s;
    e.video = (mode == 2'd1);
    e.data  = data;
    for (int ln = 0; ln < NCH; ln++) begin
      case (mode)
        2'd1: s = enc_video(ln, data[8*ln +: 8]);
        2'd0: begin
          s = CTL[ctrl[2*ln +: 2]];
          cnt[ln] = 0;
        end
        2'd2: begin
          s = TERC[terc[4*ln +: 4]];
          cnt[ln] = 0;
        end
        default: begin
          s = (ln % 3 == 1) ? 10'b0100110011
                            : 10'b1011001100;
          cnt[ln] = 0;
        end
      endcase
      e.tmds[10*ln +: 10] = s;
      e.disp[DW*ln +: DW] = DW'(cnt[ln]);
    end
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.tmds  = {NCH{CTRL0}};
    e.disp  = '0;
    e.video = 1'b0;
    e.data  = '0;
    return e;
  endfunction

  task automatic apply(
    input bit               ce,
    input bit               rst,
    input logic [1:0]       mode,
    input logic [NCH*8-1:0] data,
    input logic [NCH*2-1:0] ctrl,
    input logic [NCH*4-1:0] terc
  );
    bus.in_ce   = ce;
    rst_n       = rst;
    bus.in_mode = mode;
    bus.in_data = data;
    bus.in_ctrl = ctrl;
    bus.in_terc = terc;
    if (!rst) begin
      sb.delete();
      sb.push_back(rst_exp());
      for (int ln = 0; ln < NCH; ln++)
        cnt[ln] = 0;
    end else if (ce) begin
      sb.push_back(model(mode, data, ctrl, terc));
    end
  endtask

  task automatic step(
    input bit               ce,
    input bit               rst,
    input logic [1:0]       mode,
    input logic [NCH*8-1:0] data,
    input logic [NCH*2-1:0] ctrl,
    input logic [NCH*4-1:0] terc
  );
    @(negedge pix_clk);
    apply(ce, rst, mode, data, ctrl, terc);
  endtask

  // Monitor: one pop per enabled edge, freeze check otherwise
  initial begin
    bit         ce_s, rst_s;
    exp_t       e;
    logic [9:0] s;
    logic [7:0] dd, dec;
    logic signed [DW-1:0] dv;
    forever begin
      @(posedge pix_clk);
      ce_s  = bus.in_ce;
      rst_s = rst_n;
      #1;
      if (!rst_s) begin
        e = rst_exp();
        chk("reset_tmds", 64'(bus.out_tmds),
            64'(e.tmds));
        chk("reset_disp", 64'(bus.out_disp), 64'd0);
        last = e;
      end else if (ce_s) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          chk("tmds", 64'(bus.out_tmds),
              64'(e.tmds));
          chk("disp", 64'(bus.out_disp),
              64'(e.disp));
          last = e;
          if (e.video) begin
            for (int ln = 0; ln < NCH; ln++) begin
              dv = bus.out_disp[DW*ln +: DW];
              chk("disp_bound",
                  64'(dv >= -10 && dv <= 10), 64'd1);
              s  = bus.out_tmds[10*ln +: 10];
              dd = s[9] ? ~s[7:0] : s[7:0];
              dec[0] = dd[0];
              for (int k = 1; k < 8; k++)
                dec[k] = s[8] ? (dd[k] ^ dd[k-1])
                              : !(dd[k] ^ dd[k-1]);
              chk("decode", 64'(dec),
                  64'(e.data[8*ln +: 8]));
            end
          end
        end
      end else begin
        chk("stall_tmds", 64'(bus.out_tmds),
            64'(last.tmds));
        chk("stall_disp", 64'(bus.out_disp),
            64'(last.disp));
      end
    end
  end

  initial begin
    logic [1:0]  md;
    logic [31:0] rd;
    bit          ce, rs;

    // Reset held with video traffic present
    apply(1'b1, 1'b0, 2'd1, 32'($urandom()),
          8'($urandom()), 16'($urandom()));
    for (int k = 0; k < 2; k++)
      step(1'($urandom()), 1'b0, 2'd1,
           32'($urandom()), 8'($urandom()),
           16'($urandom()));

    // lane0 = 00 twice, lane1 = FF twice
    step(1'b1, 1'b1, 2'd1, 32'h0000FF00,
         8'h00, 16'h0);
    @(negedge pix_clk);
    chk("lat_l0_not_yet",
        64'(bus.out_tmds[9:0]), 64'(CTRL0));
    apply(1'b1, 1'b1, 2'd1, 32'h0000FF00,
          8'h00, 16'h0);
    @(negedge pix_clk);
    chk("v00_first", 64'(bus.out_tmds[9:0]),
        64'(10'b0100000000));
    chk("v00_first_disp", 64'(bus.out_disp[5:0]),
        64'(6'h38));
    chk("vFF_first", 64'(bus.out_tmds[19:10]),
        64'(10'b1000000000));
    chk("vFF_first_disp",
        64'(bus.out_disp[11:6]), 64'(6'h38));
    apply(1'b1, 1'b1, 2'd0, 32'h0, 8'h00, 16'h0);
    @(negedge pix_clk);
    chk("v00_second", 64'(bus.out_tmds[9:0]),
        64'(10'b1111111111));
    chk("v00_second_disp",
        64'(bus.out_disp[5:0]), 64'(6'h02));
    apply(1'b1, 1'b1, 2'd0, 32'h0, 8'h00, 16'h0);

    // Control, TERC4 and guard-band sweeps
    for (int c = 0; c < 4; c++) begin
      rd = 32'(c);
      step(1'b1, 1'b1, 2'd0, 32'($urandom()),
           {4{rd[1:0]}}, 16'h0);
    end
    for (int t = 0; t < 16; t++) begin
      rd = 32'(t);
      step(1'b1, 1'b1, 2'd2, 32'($urandom()),
           8'h0, {4{rd[3:0]}});
    end
    step(1'b1, 1'b1, 2'd3, 32'($urandom()),
         8'h0, 16'h0);
    step(1'b1, 1'b1, 2'd0, 32'h0, 8'h0, 16'h0);
    @(negedge pix_clk);
    chk("guard_l3", 64'(bus.out_tmds[39:30]),
        64'(10'b1011001100));
    chk("guard_l1", 64'(bus.out_tmds[19:10]),
        64'(10'b0100110011));
    chk("guard_disp", 64'(bus.out_disp), 64'd0);
    apply(1'b1, 1'b1, 2'd1, 32'($urandom()),
          8'h0, 16'h0);

    // Random stream with stalls, mode mixing, reset pulse
    for (int i = 0; i < 20000; i++) begin
      ce = ($urandom_range(3) != 0);
      rs = !(i == 9000 || i == 9001);
      if (i < 12000 || $urandom_range(9) < 7)
        md = 2'd1;
      else
        md = ($urandom_range(2) == 0) ? 2'd0 :
             ($urandom_range(1) == 0) ? 2'd2 : 2'd3;
      step(ce, rs, md, 32'($urandom()),
           8'($urandom()), 16'($urandom()));
    end

    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 2'd0, 32'h0, 8'h0, 16'h0);
    @(negedge pix_clk);
    chk("sb_residual", 64'(sb.size()), 64'd1);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
